// File: rtl/ptp_bridge_ts_match_if.sv
// ptp_bridge_ts_match_if: request, timestamp and retirement bundle
// for the PTP egress timestamp matcher.
interface ptp_bridge_ts_match_if #(
    parameter int FP_W  = 8,
    parameter int TS_W  = 96,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic            reqVld;
    logic [FP_W-1:0] reqFp;
    logic            reqRdy;
    logic            tsVld;
    logic [TS_W-1:0] tsData;
    logic            outVld;
    logic [FP_W-1:0] outFp;
    logic [TS_W-1:0] outTs;
    logic            outTimeout;
    logic            ovfErr;
    logic            orphanErr;
    logic [LW-1:0]   fillLvl;

    modport slave (
        input  reqVld, reqFp, tsVld, tsData,
        output reqRdy, outVld, outFp, outTs, outTimeout,
        output ovfErr, orphanErr, fillLvl
    );

    modport master (
        output reqVld, reqFp, tsVld, tsData,
        input  reqRdy, outVld, outFp, outTs, outTimeout,
        input  ovfErr, orphanErr, fillLvl
    );
endinterface

// File: rtl/ptp_bridge_ts_match.sv
// ptp_bridge_ts_match: pairs egress PTP fingerprints with the MAC's
// returned timestamps in order; stale heads retire with a timeout flag.
module ptp_bridge_ts_match #(
    parameter int FP_W    = 8,
    parameter int TS_W    = 96,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst_n,
    ptp_bridge_ts_match_if.slave bus_io
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic [FP_W-1:0] mem_q [DEPTH];

    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     fill_q, fill_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            out_vld_q, out_vld_d;
    logic [FP_W-1:0] out_fp_q, out_fp_d;
    logic [TS_W-1:0] out_ts_q, out_ts_d;
    logic            out_to_q, out_to_d;
    logic            orphan_q, orphan_d;

    logic full, empty, push, match, tmo, pop;

    // Occupancy, push/pop decisions and next-state of all registers.
    always_comb begin
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        push  = bus_io.reqVld && !full;
        match = bus_io.tsVld && !empty;
        tmo   = !empty && (timer_q == TMAX) && !bus_io.tsVld;
        pop   = match || tmo;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = wr_ptr_d - rd_ptr_d;

        timer_d = timer_q;
        if (empty || pop) begin
            timer_d = '0;
        end else if (timer_q != TMAX) begin
            timer_d = timer_q + 1'b1;
        end

        out_vld_d = pop;
        out_fp_d  = out_fp_q;
        out_ts_d  = out_ts_q;
        out_to_d  = out_to_q;
        if (pop) begin
            out_fp_d = mem_q[rd_ptr_q[AW-1:0]];
            out_ts_d = match ? bus_io.tsData : '0;
            out_to_d = !match;
        end

        orphan_d = bus_io.tsVld && empty;
    end

    // Fingerprint storage; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus_io.reqFp;
        end
    end

    // Pointers, head timer and registered retirement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            timer_q   <= '0;
            out_vld_q <= 1'b0;
            out_fp_q  <= '0;
            out_ts_q  <= '0;
            out_to_q  <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            timer_q   <= timer_d;
            out_vld_q <= out_vld_d;
            out_fp_q  <= out_fp_d;
            out_ts_q  <= out_ts_d;
            out_to_q  <= out_to_d;
            orphan_q  <= orphan_d;
        end
    end

    assign bus_io.reqRdy     = !full;
    assign bus_io.ovfErr     = bus_io.reqVld && full;
    assign bus_io.outVld     = out_vld_q;
    assign bus_io.outFp      = out_fp_q;
    assign bus_io.outTs      = out_ts_q;
    assign bus_io.outTimeout = out_to_q;
    assign bus_io.orphanErr  = orphan_q;
    assign bus_io.fillLvl    = fill_q;
endmodule

// File: doc/ptp_bridge_ts_match.md
Name: ptp_bridge_ts_match

Overview:
- Matches egress PTP timestamp requests with the timestamps that the MAC returns later.
- Sits directly downstream of the fixed-latency request pipeline. That pipeline delays the TX fingerprint to the MAC launch point; its output is this block's req* input.
- Holds outstanding fingerprints in order and pairs each returned timestamp with the oldest one.
- Retires an entry with a timeout flag if no timestamp returns in time.

Parameters:
- FP_W, 8, fingerprint width.
- TS_W, 96, timestamp width (48b sec + 32b ns + 16b frac ns).
- DEPTH, 16, outstanding-request capacity; power of 2, ≥2.
- TIMEOUT, 1024, cycles the head entry may wait before forced retirement; ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- reqVld  in  1  fingerprint request valid
- reqFp  in  FP_W  fingerprint
- reqRdy  out  1  request accepted this cycle when reqVld=1
- tsVld  in  1  returned timestamp valid, single-cycle pulse, no backpressure
- tsData  in  TS_W  returned timestamp
- outVld  out  1  matched/timed-out result valid, single-cycle pulse
- outFp  out  FP_W  fingerprint of retired entry
- outTs  out  TS_W  matched timestamp; 0 on timeout
- outTimeout  out  1  result is a timeout retirement
- ovfErr  out  1  pulse: reqVld while full, request dropped
- orphanErr  out  1  pulse: tsVld with no outstanding entry, timestamp dropped
- fillLvl  out  $clog2(DEPTH)+1  outstanding entry count

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FIFO empty; rd/wr pointers 0; timer 0; all outputs 0 except reqRdy = 1.
- Storage: circular FIFO of DEPTH fingerprints. Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - full = (ptr MSBs differ, LSBs equal); empty = (ptrs equal).
  - fillLvl = wrPtr − rdPtr, registered with the pointers.
- reqRdy = !full, combinational from registered state.
- Push: occurs on reqVld && reqRdy; entry is visible at head the next cycle.
- Full case: reqVld while full asserts ovfErr for exactly that cycle; request is lost, state unchanged.
  - A pop in the same cycle does not free space for that request.
- Pop sources, evaluated on the registered head:
  - (a) match: tsVld && !empty.
  - (b) timeout: !empty && timer == TIMEOUT−1 && !tsVld.
  - Match has priority over timeout in the same cycle.
- Retirement output (1-cycle latency, all registered):
  - Pop at cycle t gives outVld=1 at t+1.
  - outFp = head fingerprint.
  - Match: outTs = tsData sampled at t, outTimeout=0.
  - Timeout: outTs = 0, outTimeout=1.
  - With no pop, outVld=0; outFp/outTs/outTimeout hold their previous values.
- Orphan: tsVld && empty asserts orphanErr at t+1, outVld=0.
  - This includes a tsVld in the same cycle as the first push into an empty FIFO; the push is not yet visible.
- Simultaneous push and pop in a non-full FIFO: both happen, fillLvl unchanged.
- Head timer:
  - Held at 0 while empty.
  - Increments each cycle while !empty.
  - Clears to 0 on any pop, so the next head starts a fresh TIMEOUT window beginning the cycle after the pop.
  - Saturates at TIMEOUT−1; width $clog2(TIMEOUT).
- Pointer wrap: natural modulo 2·DEPTH. No special handling beyond the MSB compare.
- Reset mid-operation: all outstanding entries are discarded with no outVld and no error pulses.
  - Timestamps arriving after reset deassertion are orphans.
- No X propagation: FIFO storage need not be reset, but outFp must never be driven from an unwritten entry.

Test Plan:
- Single match: push fp 0x5A; tsVld with tsData=0x1234 at 10 cycles later → outVld 1 cycle after tsVld, outFp=0x5A, outTs=0x1234, outTimeout=0, fillLvl 1→0.
- Ordered burst: push fp 0..15 back-to-back, then 16 tsVld pulses with ts=100+i.
  - reqRdy drops after the 16th push; fillLvl=16.
  - Outputs are fp i paired with ts 100+i in order; a 17th reqVld while full → ovfErr pulse, fillLvl stays 16.
- Timeout, TIMEOUT=8: push fp 0x11, no ts → outVld with outTimeout=1, outTs=0, outFp=0x11 exactly 8 cycles after the head became valid (+1 output latency).
  - Second queued entry times out 8 cycles after that pop.
- Timeout/ts collision: tsVld arrives on the cycle timer==TIMEOUT−1 → match result (outTimeout=0); no extra retirement follows.
- Orphans:
  - tsVld with FIFO empty → orphanErr pulse, outVld=0.
  - tsVld coincident with the first push → orphanErr; the pushed entry remains, fillLvl=1.
- Wrap and reset: 40 push/match pairs with interleaved simultaneous push+pop → data order intact across pointer wrap.
  - Assert rst_n low with 5 outstanding → fillLvl=0, reqRdy=1, no outVld; a subsequent tsVld → orphanErr.
